// File: rtl/trg_src_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : trg_src_gen_if
// Description : Control/status bundle for the trigger-source front end.
//               The slave modport is the view taken by trg_src_gen; the
//               master modport is the view of whatever drives and observes it.
// Revision    : 1.0  initial release
// ============================================================================
interface trg_src_gen_if;
    // External trigger path
    logic        ext_trg_in;
    logic        ext_enb_in;
    // Cycled trigger control
    logic        cyc_start_in;
    logic        cyc_stop_in;
    logic [15:0] cyc_period_in;
    logic [15:0] cyc_num_in;
    // Trigger sources and status
    logic        ext_trg_syn_out;
    logic        cycled_trg_out;
    logic        cyc_busy_out;
    logic [15:0] cyc_sent_cnt_out;
    logic [15:0] ext_trg_cnt_out;

    modport master (
        output ext_trg_in, ext_enb_in, cyc_start_in, cyc_stop_in,
               cyc_period_in, cyc_num_in,
        input  ext_trg_syn_out, cycled_trg_out, cyc_busy_out,
               cyc_sent_cnt_out, ext_trg_cnt_out
    );

    modport slave (
        input  ext_trg_in, ext_enb_in, cyc_start_in, cyc_stop_in,
               cyc_period_in, cyc_num_in,
        output ext_trg_syn_out, cycled_trg_out, cyc_busy_out,
               cyc_sent_cnt_out, ext_trg_cnt_out
    );
endinterface
`default_nettype wire

// File: rtl/trg_src_gen.sv
`default_nettype none
// ============================================================================
// Module      : trg_src_gen
// Description : Trigger-source front end. Produces a synchronized,
//               glitch-filtered one-clock pulse from the asynchronous external
//               trigger, and a programmable periodic (cycled) trigger burst.
//               Optional macro TRG_SRC_EXT_CNT_EN builds a 16-bit counter of
//               accepted external triggers; without it ext_trg_cnt_out is 0.
// Revision    : 1.0  initial release
// ============================================================================
module trg_src_gen #(
    parameter int TICK_1US      = 50,
    parameter int EXT_MIN_WIDTH = 3
) (
    input  logic         clk_in,
    input  logic         rst_in,
    trg_src_gen_if.slave trg_if
);

    // Filter counter must be able to hold EXT_MIN_WIDTH itself.
    localparam int              c_FLT_W    = $clog2(EXT_MIN_WIDTH) + 1;
    localparam logic [c_FLT_W-1:0] c_FLT_MAX = c_FLT_W'(EXT_MIN_WIDTH);
    localparam logic [c_FLT_W-1:0] c_FLT_ARM = c_FLT_W'(EXT_MIN_WIDTH - 1);

    localparam int              c_PRE_W    = (TICK_1US > 1) ? $clog2(TICK_1US) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_1US - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    // ------------------------------------------------------------------
    // External trigger path
    // ------------------------------------------------------------------
    logic               r_sync_meta;
    logic               r_sync_lvl;
    logic [c_FLT_W-1:0] r_flt_cnt;
    logic               r_ext_pulse;

    // Two-stage synchronizer for the asynchronous external trigger.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sync_meta <= 1'b0;
            r_sync_lvl  <= 1'b0;
        end else begin
            r_sync_meta <= trg_if.ext_trg_in;
            r_sync_lvl  <= r_sync_meta;
        end
    end

    // Width filter: one pulse per high level, issued the clock the counter
    // reaches the minimum width; saturation blocks any repeat.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_flt_cnt   <= '0;
            r_ext_pulse <= 1'b0;
        end else begin
            r_ext_pulse <= 1'b0;
            if (!trg_if.ext_enb_in || !r_sync_lvl) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt != c_FLT_MAX) begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
                if (r_flt_cnt == c_FLT_ARM) begin
                    r_ext_pulse <= 1'b1;
                end
            end
        end
    end

    assign trg_if.ext_trg_syn_out = r_ext_pulse;

`ifdef TRG_SRC_EXT_CNT_EN
    logic [15:0] r_ext_cnt;

    // Free-running count of accepted external triggers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_ext_cnt <= 16'd0;
        end else if (r_ext_pulse) begin
            r_ext_cnt <= r_ext_cnt + 16'd1;
        end
    end

    assign trg_if.ext_trg_cnt_out = r_ext_cnt;
`else
    assign trg_if.ext_trg_cnt_out = 16'd0;
`endif

    // ------------------------------------------------------------------
    // Cycled trigger generator
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [15:0]        r_period;
    logic [15:0]        r_num;
    logic [c_PRE_W-1:0] r_pre;
    logic [15:0]        r_us;
    logic [15:0]        r_sent;
    logic               r_cyc_pulse;

    logic               w_pre_wrap;
    logic               w_period_hit;
    logic [15:0]        w_sent_next;

    assign w_pre_wrap   = (r_pre == c_PRE_LAST);
    assign w_period_hit = w_pre_wrap && (r_us == (r_period - 16'd1));
    assign w_sent_next  = r_sent + 16'd1;

    // Run-control FSM with prescaler, microsecond counter and pulse issue.
    // Stop is checked before the period match so it suppresses a due pulse.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= c_ST_IDLE;
            r_period    <= 16'd0;
            r_num       <= 16'd0;
            r_pre       <= '0;
            r_us        <= 16'd0;
            r_sent      <= 16'd0;
            r_cyc_pulse <= 1'b0;
        end else begin
            r_cyc_pulse <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (trg_if.cyc_start_in && !trg_if.cyc_stop_in) begin
                        r_state <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    r_period <= (trg_if.cyc_period_in == 16'd0) ? 16'd1 : trg_if.cyc_period_in;
                    r_num    <= trg_if.cyc_num_in;
                    r_pre    <= '0;
                    r_us     <= 16'd0;
                    r_sent   <= 16'd0;
                    r_state  <= c_ST_RUN;
                end
                c_ST_RUN: begin
                    if (trg_if.cyc_stop_in) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
                        if (w_period_hit) begin
                            r_us        <= 16'd0;
                            r_cyc_pulse <= 1'b1;
                            r_sent      <= w_sent_next;
                            if ((r_num != 16'd0) && (w_sent_next == r_num)) begin
                                r_state <= c_ST_DONE;
                            end
                        end else if (w_pre_wrap) begin
                            r_us <= r_us + 16'd1;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign trg_if.cycled_trg_out   = r_cyc_pulse;
    assign trg_if.cyc_busy_out     = (r_state == c_ST_RUN);
    assign trg_if.cyc_sent_cnt_out = r_sent;

endmodule
`default_nettype wire

// File: tb/tb_trg_src_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_trg_src_gen
// Description : Self-checking bench for trg_src_gen. Expected pulse edges are
//               queued when stimulus is driven and matched against the pulses
//               the DUT produces; status values are checked at chosen edges.
// Revision    : 1.0  initial release
// ============================================================================
module tb_trg_src_gen;

    localparam int c_TICK = 50;
    localparam int c_MINW = 3;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    int unsigned edge_cnt = 0;

    always #10 clk_in = ~clk_in;

    // Number of rising edges seen so far; stable when sampled on the falling edge.
    always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

    trg_src_gen_if u_if ();

    trg_src_gen #(
        .TICK_1US      (c_TICK),
        .EXT_MIN_WIDTH (c_MINW)
    ) u_dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .trg_if (u_if.slave)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned ext_q[$];
    int unsigned cyc_q[$];
    int unsigned ext_model_cnt = 0;

    typedef struct {
        int unsigned len;
        logic        enb;
        logic        exp_pulse;
    } ext_vec_t;

    ext_vec_t ext_tbl[7];

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic longint ext_cnt_exp();
`ifdef TRG_SRC_EXT_CNT_EN
        return longint'(ext_model_cnt % 65536);
`else
        return 0;
`endif
    endfunction

    // Advance to the next falling edge and reconcile observed pulses
    // against the queued expectations.
    task automatic tick();
        @(negedge clk_in);
        if (ext_q.size() != 0 && ext_q[0] < edge_cnt) begin
            n_vec++;
            n_err++;
            $display("FAIL ext_pulse: pulse missing, expected at edge %0d", ext_q.pop_front());
        end
        if (cyc_q.size() != 0 && cyc_q[0] < edge_cnt) begin
            n_vec++;
            n_err++;
            $display("FAIL cyc_pulse: pulse missing, expected at edge %0d", cyc_q.pop_front());
        end
        if (u_if.ext_trg_syn_out) begin
            if (ext_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL ext_pulse: got pulse at edge %0d, expected none", edge_cnt);
            end else begin
                check("ext_pulse_edge", edge_cnt, ext_q.pop_front());
            end
        end
        if (u_if.cycled_trg_out) begin
            if (cyc_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL cyc_pulse: got pulse at edge %0d, expected none", edge_cnt);
            end else begin
                check("cyc_pulse_edge", edge_cnt, cyc_q.pop_front());
            end
        end
    endtask

    task automatic run_until(input int unsigned e);
        while (edge_cnt < e) tick();
    endtask

    // Pulse start for one clock; returns the edge that samples it.
    task automatic start_run(input logic [15:0] period, input logic [15:0] num,
                             output int unsigned s);
        u_if.cyc_period_in = period;
        u_if.cyc_num_in    = num;
        u_if.cyc_start_in  = 1'b1;
        s = edge_cnt + 1;
        tick();
        u_if.cyc_start_in  = 1'b0;
    endtask

    initial begin
        int unsigned s;

        u_if.ext_trg_in    = 1'b0;
        u_if.ext_enb_in    = 1'b1;
        u_if.cyc_start_in  = 1'b0;
        u_if.cyc_stop_in   = 1'b0;
        u_if.cyc_period_in = 16'd0;
        u_if.cyc_num_in    = 16'd0;

        // ---------------- reset state ----------------
        rst_in = 1'b1;
        repeat (3) tick();
        check("rst_ext_syn",   u_if.ext_trg_syn_out,  0);
        check("rst_cyc_trg",   u_if.cycled_trg_out,   0);
        check("rst_busy",      u_if.cyc_busy_out,     0);
        check("rst_sent_cnt",  u_if.cyc_sent_cnt_out, 0);
        check("rst_ext_cnt",   u_if.ext_trg_cnt_out,  0);
        rst_in = 1'b0;
        repeat (2) tick();

        // ---------------- external path table ----------------
        ext_tbl[0] = '{10, 1'b1, 1'b1};
        ext_tbl[1] = '{2,  1'b1, 1'b0};
        ext_tbl[2] = '{1,  1'b1, 1'b0};
        ext_tbl[3] = '{3,  1'b1, 1'b1};
        ext_tbl[4] = '{4,  1'b1, 1'b1};
        ext_tbl[5] = '{10, 1'b0, 1'b0};
        ext_tbl[6] = '{25, 1'b1, 1'b1};

        for (int i = 0; i < 7; i++) begin
            u_if.ext_enb_in = ext_tbl[i].enb;
            u_if.ext_trg_in = 1'b1;
            // First sampled at edge N = edge_cnt+1; pulse after edge N+MINW+1.
            if (ext_tbl[i].exp_pulse) begin
                ext_q.push_back(edge_cnt + 2 + c_MINW);
                ext_model_cnt++;
            end
            repeat (ext_tbl[i].len) tick();
            u_if.ext_trg_in = 1'b0;
            repeat (8) tick();
            check("ext_cnt_row", u_if.ext_trg_cnt_out, ext_cnt_exp());
        end

        // Enabling while the synchronized level is already high.
        u_if.ext_enb_in = 1'b0;
        u_if.ext_trg_in = 1'b1;
        repeat (5) tick();
        u_if.ext_enb_in = 1'b1;
        ext_q.push_back(edge_cnt + c_MINW);
        ext_model_cnt++;
        repeat (8) tick();
        u_if.ext_trg_in = 1'b0;
        repeat (6) tick();
        check("ext_cnt_late_enb", u_if.ext_trg_cnt_out, ext_cnt_exp());

        // ---------------- cycled: period 2, three pulses ----------------
        start_run(16'd2, 16'd3, s);
        check("c1_busy_load", u_if.cyc_busy_out, 0);
        for (int k = 1; k <= 3; k++) cyc_q.push_back(s + 1 + k * 2 * c_TICK);
        tick();
        check("c1_busy_run", u_if.cyc_busy_out, 1);
        // Latched values must not follow the inputs during the run.
        u_if.cyc_period_in = 16'd7;
        u_if.cyc_num_in    = 16'd1;
        run_until(s + 300);
        check("c1_busy_pre", u_if.cyc_busy_out, 1);
        check("c1_sent_pre", u_if.cyc_sent_cnt_out, 2);
        tick();
        check("c1_pulse_last", u_if.cycled_trg_out, 1);
        check("c1_busy_done", u_if.cyc_busy_out, 0);
        check("c1_sent_done", u_if.cyc_sent_cnt_out, 3);
        repeat (150) tick();
        check("c1_sent_hold", u_if.cyc_sent_cnt_out, 3);
        check("c1_busy_idle", u_if.cyc_busy_out, 0);

        // ---------------- start with coincident stop is ignored ----------------
        u_if.cyc_start_in = 1'b1;
        u_if.cyc_stop_in  = 1'b1;
        tick();
        u_if.cyc_start_in = 1'b0;
        u_if.cyc_stop_in  = 1'b0;
        repeat (3) tick();
        check("ss_busy", u_if.cyc_busy_out, 0);
        check("ss_sent", u_if.cyc_sent_cnt_out, 3);

        // ---------------- cycled: period 0 unlimited, stop on due pulse ----------------
        start_run(16'd0, 16'd0, s);
        for (int k = 1; k <= 5; k++) cyc_q.push_back(s + 1 + k * c_TICK);
        tick();
        check("c2_sent_clear", u_if.cyc_sent_cnt_out, 0);
        run_until(s + 120);
        u_if.cyc_start_in = 1'b1;  // must be ignored in RUN
        tick();
        u_if.cyc_start_in = 1'b0;
        run_until(s + 300);
        check("c2_sent_pre", u_if.cyc_sent_cnt_out, 5);
        check("c2_busy_pre", u_if.cyc_busy_out, 1);
        u_if.cyc_stop_in = 1'b1;
        tick();
        u_if.cyc_stop_in = 1'b0;
        check("c2_stop_nopulse", u_if.cycled_trg_out, 0);
        check("c2_stop_busy", u_if.cyc_busy_out, 0);
        check("c2_stop_sent", u_if.cyc_sent_cnt_out, 5);
        repeat (120) tick();
        check("c2_sent_hold", u_if.cyc_sent_cnt_out, 5);

        // ---------------- reset mid-run ----------------
        start_run(16'd1, 16'd0, s);
        cyc_q.push_back(s + 1 + c_TICK);
        cyc_q.push_back(s + 1 + 2 * c_TICK);
        run_until(s + 120);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        ext_model_cnt = 0;
        check("mr_busy", u_if.cyc_busy_out, 0);
        check("mr_sent", u_if.cyc_sent_cnt_out, 0);
        check("mr_cyc_trg", u_if.cycled_trg_out, 0);
        check("mr_ext_syn", u_if.ext_trg_syn_out, 0);
        check("mr_ext_cnt", u_if.ext_trg_cnt_out, 0);
        repeat (60) tick();
        check("mr_busy_after", u_if.cyc_busy_out, 0);

        start_run(16'd1, 16'd2, s);
        cyc_q.push_back(s + 1 + c_TICK);
        cyc_q.push_back(s + 1 + 2 * c_TICK);
        tick();
        check("rs_busy", u_if.cyc_busy_out, 1);
        check("rs_sent", u_if.cyc_sent_cnt_out, 0);
        run_until(s + 1 + 2 * c_TICK);
        check("rs_sent_done", u_if.cyc_sent_cnt_out, 2);
        check("rs_busy_done", u_if.cyc_busy_out, 0);
        repeat (60) tick();

        // ---------------- coincident external and cycled pulses ----------------
        start_run(16'd1, 16'd1, s);
        cyc_q.push_back(s + 1 + c_TICK);
        run_until(s + c_TICK - 4);
        u_if.ext_trg_in = 1'b1;
        ext_q.push_back(edge_cnt + 2 + c_MINW);
        ext_model_cnt++;
        run_until(s + 1 + c_TICK);
        check("co_ext", u_if.ext_trg_syn_out, 1);
        check("co_cyc", u_if.cycled_trg_out, 1);
        repeat (3) tick();
        u_if.ext_trg_in = 1'b0;
        repeat (10) tick();
        check("co_ext_cnt", u_if.ext_trg_cnt_out, ext_cnt_exp());
        check("co_sent", u_if.cyc_sent_cnt_out, 1);
        check("co_busy", u_if.cyc_busy_out, 0);

        // ---------------- drain ----------------
        repeat (20) tick();
        check("ext_pending", ext_q.size(), 0);
        check("cyc_pending", cyc_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
